// File: rtl/swap_initiator.sv
// swap_initiator
//
// Command-side front end for the swap register file. Swap requests (an
// address pair) arrive on a valid/ready handshake and are buffered in a small
// FIFO. One request at a time is issued to the swapper: a one-cycle `swap`
// pulse, with `address_A`/`address_B` held stable for the swapper's three
// phases. `done` marks completion, so upstream never tracks swapper timing.
//
// Optional feature macro: SWAP_ADDR_CHECK_EN
//   defined   : requests with a zero address or A == B are dropped at accept
//               (the handshake still completes) and `err` pulses one cycle later.
//   undefined : every accepted request is queued unchanged; `err` is tied to 0.
//
// Ports
//   clk          rising-edge clock, shared with the swapper
//   reset        synchronous active-high reset (swapper reset_n = ~reset)
//   req_valid    request present
//   req_ready    FIFO can accept (!full && !reset), combinational
//   req_addr_a   first address of the pair
//   req_addr_b   second address of the pair
//   swap         one-cycle start pulse to the swapper
//   address_A    held pair address A
//   address_B    held pair address B
//   busy         swap in flight, issue cycle through done cycle
//   done         one-cycle pulse, current swap complete
//   queue_count  FIFO occupancy, 0..DEPTH
//   err          one-cycle pulse, request dropped by the address check

module swap_initiator #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_addr_a,
  input  logic [ADDR_WIDTH-1:0]      req_addr_b,
  output logic                       swap,
  output logic [ADDR_WIDTH-1:0]      address_A,
  output logic [ADDR_WIDTH-1:0]      address_B,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // FIFO storage holds data only and is not reset.
  logic [ADDR_WIDTH-1:0] fifo_a [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_b [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  state_t                state;
  logic [1:0]            phase;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic issue;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign req_ready   = !full && !reset;
  assign accept      = req_valid && req_ready;
  assign queue_count = count;

`ifdef SWAP_ADDR_CHECK_EN
  logic bad_pair;
  logic err_q;

  // Address 0 is the swapper's scratch slot; a self-swap is meaningless.
  assign bad_pair = (req_addr_a == '0) || (req_addr_b == '0) ||
                    (req_addr_a == req_addr_b);
  assign push     = accept && !bad_pair;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && bad_pair;
    end
  end

  assign err = err_q;
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  // A new swap may start from idle, or directly in the done cycle of the
  // previous one, giving one swap every four cycles back to back. Issue reads
  // only registered occupancy, so a request pushed this cycle cannot bypass.
  assign issue = !empty && ((state == ST_IDLE) ||
                            ((state == ST_RUN) && (phase == 2'd3)));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= req_addr_a;
      fifo_b[wr_ptr] <= req_addr_b;
    end
  end

  // Pointers wrap modulo DEPTH through natural overflow (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Phase 0 is the issue cycle; the swapper runs during phases 1..3, and
  // phase 3 is the done cycle. Addresses change only when a swap is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= 2'd0;
      swap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      address_A <= '0;
      address_B <= '0;
    end else begin
      swap <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            state     <= ST_RUN;
            phase     <= 2'd0;
            swap      <= 1'b1;
            busy      <= 1'b1;
            address_A <= fifo_a[rd_ptr];
            address_B <= fifo_b[rd_ptr];
          end
        end
        ST_RUN: begin
          unique case (phase)
            2'd0, 2'd1: begin
              phase <= phase + 1'b1;
            end
            2'd2: begin
              phase <= 2'd3;
              done  <= 1'b1;
            end
            default: begin
              if (issue) begin
                phase     <= 2'd0;
                swap      <= 1'b1;
                address_A <= fifo_a[rd_ptr];
                address_B <= fifo_b[rd_ptr];
              end else begin
                state <= ST_IDLE;
                phase <= 2'd0;
                busy  <= 1'b0;
              end
            end
          endcase
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
